// File: rtl/uart_rx.sv
// 8N1 serial receiver (optional even parity via UART_RX_PARITY_EN) with mid-bit sampling and
// one-cycle registered strobes for received bytes, framing errors and parity errors.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] outByte,
    output logic       dataReady,
    output logic       busy,
    output logic       frameErr,
    output logic       parityErr
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HalfLast = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BitLast  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e        state_q;
    logic          sync1_q;
    logic          rxs_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    out_byte_q;
    logic          data_ready_q;
    logic          busy_q;
    logic          frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q;
    logic          parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            timer_q      <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            out_byte_q   <= 8'h00;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= rx;
            rxs_q        <= sync1_q;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            timer_q      <= timer_q + TW'(1);
            case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    if (!rxs_q) begin
                        state_q <= StStart;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (timer_q == HalfLast) begin
                        timer_q <= '0;
                        idx_q   <= 3'd0;
                        // Line back high at mid start bit: treat as a glitch.
                        if (rxs_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (timer_q == BitLast) begin
                        timer_q <= '0;
                        shift_q <= {rxs_q, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (timer_q == BitLast) begin
                        timer_q   <= '0;
                        par_bad_q <= rxs_q != (^shift_q);
                        state_q   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (timer_q == BitLast) begin
                        timer_q <= '0;
                        if (!rxs_q) begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                out_byte_q   <= shift_q;
                                data_ready_q <= 1'b1;
                            end
`else
                            out_byte_q   <= shift_q;
                            data_ready_q <= 1'b1;
`endif
                        end
                    end
                end
                StBreak: begin
                    timer_q <= '0;
                    if (rxs_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign outByte   = out_byte_q;
    assign dataReady = data_ready_q;
    assign busy      = busy_q;
    assign frameErr  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parityErr = parity_err_q;
`else
    assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, checked every cycle
// against a frame-level event model (expected strobe cycle = falling edge + frame latency).
module tb_uart_rx;

    localparam int unsigned C = 4;
`ifdef UART_RX_PARITY_EN
    localparam int LAT   = C / 2 + 10 * C + 1 + 2;
    localparam int FRAME = 11 * C;
`else
    localparam int LAT   = C / 2 + 9 * C + 1 + 2;
    localparam int FRAME = 10 * C;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] outByte;
    logic       dataReady;
    logic       busy;
    logic       frameErr;
    logic       parityErr;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .outByte  (outByte),
        .dataReady(dataReady),
        .busy     (busy),
        .frameErr (frameErr),
        .parityErr(parityErr)
    );

    typedef struct {
        int         cyc;
        int         kind;  // 0 good byte, 1 framing error, 2 parity error
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic       rst_at_edge = 1'b0;
    logic       cmp_en = 1'b0;
    logic [7:0] model_byte = 8'h00;
    int         dr_count = 0;
    int         fe_count = 0;
    int         pe_count = 0;
    int         dr_cycs[$];
    logic [7:0] dr_bytes[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the event model.
    always @(negedge clk) begin
        logic exp_dr, exp_fe, exp_pe;
        ev_t  e;
        if (cmp_en) begin
            if (rst_at_edge) begin
                model_byte = 8'h00;
                check("reset_outByte", {24'd0, outByte}, 32'd0);
                check("reset_strobes", {29'd0, dataReady, frameErr, parityErr}, 32'd0);
                check("reset_busy", {31'd0, busy}, 32'd0);
            end else begin
                exp_dr = 1'b0;
                exp_fe = 1'b0;
                exp_pe = 1'b0;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    e = evq.pop_front();
                    case (e.kind)
                        0: begin
                            exp_dr     = 1'b1;
                            model_byte = e.data;
                        end
                        1: exp_fe = 1'b1;
                        default: exp_pe = 1'b1;
                    endcase
                end
                check("dataReady", {31'd0, dataReady}, {31'd0, exp_dr});
                check("frameErr", {31'd0, frameErr}, {31'd0, exp_fe});
                check("parityErr", {31'd0, parityErr}, {31'd0, exp_pe});
                check("outByte", {24'd0, outByte}, {24'd0, model_byte});
            end
            if (dataReady) begin
                dr_count++;
                dr_cycs.push_back(cyc);
                dr_bytes.push_back(outByte);
            end
            if (frameErr) fe_count++;
            if (parityErr) pe_count++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting now; leaves rx at the stop-bit value.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_ok,
                              output int fall);
        ev_t e;
        rx     = 1'b0;
        fall   = cyc;
        e.cyc  = cyc + LAT;
        e.data = d;
        e.kind = 0;
        if (!stop_v) begin
            e.kind = 1;
        end else begin
`ifdef UART_RX_PARITY_EN
            if (!par_ok) e.kind = 2;
`endif
        end
        evq.push_back(e);
        wait_cyc(C);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == 4) check("busy_midframe", {31'd0, busy}, 32'd1);
            wait_cyc(C);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? (^d) : ~(^d);
        wait_cyc(C);
`endif
        rx = stop_v;
        wait_cyc(C);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int         fall;
        int         n0;
        int         fe0;
        logic [7:0] b;
        int         r;

        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(50);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_no_strobe", dr_count + fe_count + pe_count, 0);

        // Single frame with pinned latency.
        send_frame(8'hA5, 1'b1, 1'b1, fall);
        wait_cyc(6);
`ifdef UART_RX_PARITY_EN
        check("latency", dr_cycs[0] - fall, 45);
`else
        check("latency", dr_cycs[0] - fall, 41);
`endif
        check("single_byte", {24'd0, outByte}, 32'hA5);
        check("single_count", dr_count, 1);

        // Back-to-back frames.
        n0 = dr_count;
        send_frame(8'h01, 1'b1, 1'b1, fall);
        send_frame(8'hFF, 1'b1, 1'b1, fall);
        send_frame(8'h00, 1'b1, 1'b1, fall);
        wait_cyc(6);
        check("b2b_count", dr_count - n0, 3);
        check("b2b_byte0", {24'd0, dr_bytes[n0]}, 32'h01);
        check("b2b_byte1", {24'd0, dr_bytes[n0 + 1]}, 32'hFF);
        check("b2b_byte2", {24'd0, dr_bytes[n0 + 2]}, 32'h00);
`ifdef UART_RX_PARITY_EN
        check("b2b_space0", dr_cycs[n0 + 1] - dr_cycs[n0], 44);
        check("b2b_space1", dr_cycs[n0 + 2] - dr_cycs[n0 + 1], 44);
`else
        check("b2b_space0", dr_cycs[n0 + 1] - dr_cycs[n0], 40);
        check("b2b_space1", dr_cycs[n0 + 2] - dr_cycs[n0 + 1], 40);
`endif

        // Glitch: one-cycle low pulse.
        n0 = dr_count;
        rx = 1'b0;
        wait_cyc(1);
        rx = 1'b1;
        wait_cyc(8);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_no_strobe", dr_count - n0, 0);

        // Framing error then held break.
        fe0 = fe_count;
        send_frame(8'h3C, 1'b0, 1'b1, fall);
        wait_cyc(15);
        check("break_busy", {31'd0, busy}, 32'd1);
        check("ferr_count", fe_count - fe0, 1);
        check("ferr_no_dr", dr_count - n0, 0);
        check("ferr_outByte", {24'd0, outByte}, 32'h00);
        rx = 1'b1;
        wait_cyc(6);
        check("break_release_busy", {31'd0, busy}, 32'd0);

`ifdef UART_RX_PARITY_EN
        n0 = dr_count;
        send_frame(8'h07, 1'b1, 1'b0, fall);
        wait_cyc(6);
        check("perr_count", pe_count, 1);
        check("perr_outByte", {24'd0, outByte}, 32'h00);
        send_frame(8'h07, 1'b1, 1'b1, fall);
        wait_cyc(6);
        check("par_ok_byte", {24'd0, outByte}, 32'h07);
        check("par_ok_count", dr_count - n0, 1);
`endif

        // Reset during data bit 4 of 0x55.
        n0 = dr_count;
        b  = 8'h55;
        rx = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_cyc(C);
        end
        rx = b[4];
        wait_cyc(1);
        evq.delete();
        reset = 1'b1;
        wait_cyc(2);
        rx    = 1'b1;
        reset = 1'b0;
        wait_cyc(50);
        check("rst_mid_no_strobe", dr_count - n0, 0);
        check("rst_mid_outByte", {24'd0, outByte}, 32'h00);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h12, 1'b1, 1'b1, fall);
        wait_cyc(6);
        check("after_rst_byte", {24'd0, outByte}, 32'h12);

        // Random frames, gaps, glitches, framing and parity errors.
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 2) begin
                rx = 1'b0;
                wait_cyc(1);
                rx = 1'b1;
                wait_cyc(int'($urandom_range(4, 7)));
            end
            b = 8'($urandom);
            if (r == 0) begin
                send_frame(b, 1'b0, 1'b1, fall);
                wait_cyc(int'($urandom_range(0, 8)));
                rx = 1'b1;
                wait_cyc(int'($urandom_range(2, 5)));
            end else begin
                send_frame(b, 1'b1, r != 1, fall);
                wait_cyc(int'($urandom_range(0, 3)));
            end
        end
        wait_cyc(LAT + 10);
        check("events_drained", evq.size(), 0);
        check("frame_len", FRAME, (C / 2) * 2 * (FRAME / C));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
